hex_display_scheduler: RTL

- Drives a bank of active-low 7-segment displays from a single shared hex-digit decoder (4-bit nibble in, 7-bit active-low pattern out, segment order {g,f,e,d,c,b,a}).
- On a load request it captures a packed hex value and time-multiplexes the one decoder across all digits, MSB first.
- It applies leading-zero blanking and per-digit enables, then commits all segment patterns to the outputs in a single cycle.
- It sits between result/status logic and the board HEX pins; it queues one pending load while busy.

---
 rtl/hex_display_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hex_display_scheduler.sv
// Multiplexed hex display driver: one shared 7-segment decoder scans all digits MSB first,
// applies leading-zero blanking and per-digit enables, then commits every digit at once.
module hex_display_scheduler #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned IDX_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned STG_W = 7 * (NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]            state, state_nxt;
  logic [IDX_W-1:0]      idx;
  logic                  seen_nz;
  logic [VAL_W-1:0]      sh_value;
  logic                  sh_blank_lz;
  logic [NUM_DIGITS-1:0] sh_en;
  logic                  pend;
  logic [VAL_W-1:0]      pend_value;
  logic                  pend_blank_lz;
  logic [NUM_DIGITS-1:0] pend_en;
  logic [STG_W-1:0]      staging;

  logic [3:0] nibble_c;
  logic [6:0] pattern_c;
  logic       blank_this_c;
  logic [6:0] digit_seg_c;
  logic       last_digit_c;
  logic       restart_c;

  // Shared nibble decoder (active-low, {g,f,e,d,c,b,a})
  always_comb begin
    nibble_c = sh_value[4*idx +: 4];
    pattern_c = 7'b1111111;
    case (nibble_c)
      4'h0: pattern_c = 7'b1000000;
      4'h1: pattern_c = 7'b1111001;
      4'h2: pattern_c = 7'b0100100;
      4'h3: pattern_c = 7'b0110000;
      4'h4: pattern_c = 7'b0011001;
      4'h5: pattern_c = 7'b0010010;
      4'h6: pattern_c = 7'b0000010;
      4'h7: pattern_c = 7'b1111000;
      4'h8: pattern_c = 7'b0000000;
      4'h9: pattern_c = 7'b0010000;
      4'hA: pattern_c = 7'b0001000;
      4'hB: pattern_c = 7'b0000011;
      4'hC: pattern_c = 7'b1000110;
      4'hD: pattern_c = 7'b0100001;
      4'hE: pattern_c = 7'b0000110;
      4'hF: pattern_c = 7'b0001110;
      default: pattern_c = 7'b1111111;
    endcase
  end

  // Blanking decision for the digit currently being scanned; digit 0 never zero-blanks
  always_comb begin
    blank_this_c = !sh_en[idx] ||
                   (sh_blank_lz && !seen_nz && (nibble_c == 4'h0) && (idx != '0));
    digit_seg_c  = blank_this_c ? 7'b1111111 : pattern_c;
    last_digit_c = (state == SCAN) && (idx == '0);
    restart_c    = last_digit_c && (pend || load);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SCAN;
      SCAN:    if (last_digit_c && !restart_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Scan datapath: shadow/pending capture, staging fill and atomic commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      seen_nz       <= 1'b0;
      sh_value      <= '0;
      sh_blank_lz   <= 1'b0;
      sh_en         <= '0;
      pend          <= 1'b0;
      pend_value    <= '0;
      pend_blank_lz <= 1'b0;
      pend_en       <= '0;
      staging       <= '1;
      seg_out       <= '1;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (load) begin
          sh_value    <= value;
          sh_blank_lz <= blank_lz;
          sh_en       <= digit_en;
          idx         <= IDX_TOP;
          seen_nz     <= 1'b0;
          busy        <= 1'b1;
        end
      end else if (idx != '0) begin
        staging[7*(idx-1) +: 7] <= digit_seg_c;
        seen_nz <= seen_nz | (nibble_c != 4'h0);
        idx     <= idx - 1'b1;
        if (load) begin
          pend          <= 1'b1;
          pend_value    <= value;
          pend_blank_lz <= blank_lz;
          pend_en       <= digit_en;
        end
      end else begin
        seg_out <= {staging, digit_seg_c};
        done    <= 1'b1;
        if (restart_c) begin
          // A load arriving on the final cycle supersedes any older pending request
          sh_value    <= load ? value    : pend_value;
          sh_blank_lz <= load ? blank_lz : pend_blank_lz;
          sh_en       <= load ? digit_en : pend_en;
          pend        <= 1'b0;
          idx         <= IDX_TOP;
          seen_nz     <= 1'b0;
        end else begin
          busy <= 1'b0;
        end
      end
    end
  end

endmodule
